vga_timing_gen: RTL and testbench

Parametrised VGA timing generator, the successor to the fixed 640x480 `vga` block. Porch, sync and active-area widths are set by parameters, along with sync polarity and the pixel clock divider. Adds a clock enable, line and frame strobes, and a frame counter. It drives the monitor sync pins and supplies pixel coordinates to downstream pixel generators and the BMP-dumping simulation bench.

---
 rtl/vga_timing_gen.sv | 146 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: counters, syncs, display-area flag, strobes and frame count.
// Optional colour-bar test pattern on vga_r/vga_g/vga_b when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter logic        H_POL    = 1'b0,
   parameter logic        V_POL    = 1'b0,
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned CW       = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   output logic          vga_h_sync,
   output logic          vga_v_sync,
   output logic          inDisplayArea,
   output logic [CW-1:0] CounterX,
   output logic [CW-1:0] CounterY,
   output logic          pixel_tick,
   output logic          line_start,
   output logic          frame_start,
   output logic [15:0]   frame_count
`ifdef VGA_TEST_PATTERN_EN
   ,
   output logic [7:0]    vga_r,
   output logic [7:0]    vga_g,
   output logic [7:0]    vga_b
`endif
);

   localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned H_SYNC_LO = H_ACTIVE + H_FP;
   localparam int unsigned H_SYNC_HI = H_SYNC_LO + H_SYNC;
   localparam int unsigned V_SYNC_LO = V_ACTIVE + V_FP;
   localparam int unsigned V_SYNC_HI = V_SYNC_LO + V_SYNC;
   localparam int unsigned PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   // One extra bit so range limits equal to 2^CW compare correctly.
   localparam int unsigned XW        = CW + 1;

   logic [PW-1:0] presc, presc_n;
   logic [CW-1:0] x_n, y_n;
   logic [15:0]   fc_n;
   logic          adv;
   logic          hs_n, vs_n, disp_n, ls_n, fs_n;

`ifdef VGA_TEST_PATTERN_EN
   localparam int unsigned BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
   // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black ({r,g,b}).
   localparam logic [23:0] BAR_RGB = {3'b000, 3'b001, 3'b100, 3'b101,
                                      3'b010, 3'b011, 3'b110, 3'b111};
   logic [CW-1:0] bar;
   logic [2:0]    colour;
   logic [7:0]    r_n, g_n, b_n;
`endif

   // Next-state counters and decoded outputs.
   always_comb begin
      presc_n = presc;
      x_n     = CounterX;
      y_n     = CounterY;
      fc_n    = frame_count;
      adv     = 1'b0;
      if (enable) begin
         if (presc == PW'(CLK_DIV - 1)) begin
            presc_n = '0;
            adv     = 1'b1;
         end else begin
            presc_n = presc + PW'(1);
         end
      end
      if (adv) begin
         if (CounterX == CW'(H_TOTAL - 1)) begin
            x_n = '0;
            if (CounterY == CW'(V_TOTAL - 1)) begin
               y_n  = '0;
               fc_n = frame_count + 16'd1;
            end else begin
               y_n = CounterY + CW'(1);
            end
         end else begin
            x_n = CounterX + CW'(1);
         end
      end
      hs_n   = (XW'(x_n) >= XW'(H_SYNC_LO) && XW'(x_n) < XW'(H_SYNC_HI)) ? H_POL : ~H_POL;
      vs_n   = (XW'(y_n) >= XW'(V_SYNC_LO) && XW'(y_n) < XW'(V_SYNC_HI)) ? V_POL : ~V_POL;
      disp_n = (XW'(x_n) < XW'(H_ACTIVE)) && (XW'(y_n) < XW'(V_ACTIVE));
      ls_n   = adv && (x_n == '0);
      fs_n   = ls_n && (y_n == '0);
   end

`ifdef VGA_TEST_PATTERN_EN
   // Colour bar lookup from the next column.
   always_comb begin
      bar    = x_n / CW'(BAR_W);
      colour = 3'b000;
      if (XW'(bar) < XW'(8)) colour = BAR_RGB[5'(bar[2:0]) * 5'd3 +: 3];
      r_n = disp_n ? {8{colour[2]}} : 8'h00;
      g_n = disp_n ? {8{colour[1]}} : 8'h00;
      b_n = disp_n ? {8{colour[0]}} : 8'h00;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         presc         <= '0;
         CounterX      <= '0;
         CounterY      <= '0;
         frame_count   <= '0;
         vga_h_sync    <= ~H_POL;
         vga_v_sync    <= ~V_POL;
         inDisplayArea <= 1'b0;
         pixel_tick    <= 1'b0;
         line_start    <= 1'b0;
         frame_start   <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
         vga_r         <= 8'h00;
         vga_g         <= 8'h00;
         vga_b         <= 8'h00;
`endif
      end else begin
         presc         <= presc_n;
         CounterX      <= x_n;
         CounterY      <= y_n;
         frame_count   <= fc_n;
         vga_h_sync    <= hs_n;
         vga_v_sync    <= vs_n;
         inDisplayArea <= disp_n;
         pixel_tick    <= adv;
         line_start    <= ls_n;
         frame_start   <= fs_n;
`ifdef VGA_TEST_PATTERN_EN
         vga_r         <= r_n;
         vga_g         <= g_n;
         vga_b         <= b_n;
`endif
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: two small geometries against an arithmetic pixel-count model.
module tb_vga_timing_gen;

   // DUT A: small frame with a divide-by-3 pixel clock.
   localparam int unsigned HA_A = 16, HF_A = 2, HS_A = 3, HB_A = 3;
   localparam int unsigned VA_A = 8,  VF_A = 1, VS_A = 2, VB_A = 1;
   localparam int unsigned DIV_A = 3;
   // DUT B: tiny frame, every clk a pixel, active-high hsync.
   localparam int unsigned HA_B = 8, HF_B = 1, HS_B = 2, HB_B = 1;
   localparam int unsigned VA_B = 4, VF_B = 1, VS_B = 1, VB_B = 1;
   localparam int unsigned DIV_B = 1;

`ifdef VGA_TEST_PATTERN_EN
   localparam int unsigned VW = 66;
`else
   localparam int unsigned VW = 42;
`endif
   typedef logic [VW-1:0] vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b1;

   logic       hs_a, vs_a, disp_a, tick_a, ls_a, fs_a;
   logic [9:0] x_a, y_a;
   logic [15:0] fc_a;
   logic       hs_b, vs_b, disp_b, tick_b, ls_b, fs_b;
   logic [9:0] x_b, y_b;
   logic [15:0] fc_b;
`ifdef VGA_TEST_PATTERN_EN
   logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
`endif

   int unsigned e_a = 0, e_b = 0;
   bit fresh = 1'b1, tk_a = 1'b0, tk_b = 1'b0;
   int n_tests = 0, n_fail = 0;
   vec_t obs_a, obs_b, exp_a, exp_b;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_ACTIVE(HA_A), .H_FP(HF_A), .H_SYNC(HS_A), .H_BP(HB_A),
      .V_ACTIVE(VA_A), .V_FP(VF_A), .V_SYNC(VS_A), .V_BP(VB_A),
      .H_POL(1'b0), .V_POL(1'b0), .CLK_DIV(DIV_A), .CW(10)
   ) dut_a (
      .clk(clk), .reset(reset), .enable(enable),
      .vga_h_sync(hs_a), .vga_v_sync(vs_a), .inDisplayArea(disp_a),
      .CounterX(x_a), .CounterY(y_a), .pixel_tick(tick_a),
      .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
`ifdef VGA_TEST_PATTERN_EN
      , .vga_r(r_a), .vga_g(g_a), .vga_b(b_a)
`endif
   );

   vga_timing_gen #(
      .H_ACTIVE(HA_B), .H_FP(HF_B), .H_SYNC(HS_B), .H_BP(HB_B),
      .V_ACTIVE(VA_B), .V_FP(VF_B), .V_SYNC(VS_B), .V_BP(VB_B),
      .H_POL(1'b1), .V_POL(1'b0), .CLK_DIV(DIV_B), .CW(10)
   ) dut_b (
      .clk(clk), .reset(reset), .enable(enable),
      .vga_h_sync(hs_b), .vga_v_sync(vs_b), .inDisplayArea(disp_b),
      .CounterX(x_b), .CounterY(y_b), .pixel_tick(tick_b),
      .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
`ifdef VGA_TEST_PATTERN_EN
      , .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
`endif
   );

   assign obs_a = {hs_a, vs_a, disp_a, tick_a, ls_a, fs_a, fc_a, y_a, x_a
`ifdef VGA_TEST_PATTERN_EN
                   , r_a, g_a, b_a
`endif
                  };
   assign obs_b = {hs_b, vs_b, disp_b, tick_b, ls_b, fs_b, fc_b, y_b, x_b
`ifdef VGA_TEST_PATTERN_EN
                   , r_b, g_b, b_b
`endif
                  };

   // Expected outputs from the number of enabled clks since reset: pixel index p = e / div.
   function automatic vec_t model(input int unsigned e, input bit fr, input bit tk,
                                  input int unsigned ha, input int unsigned hf,
                                  input int unsigned hsw, input int unsigned hb,
                                  input int unsigned va, input int unsigned vf,
                                  input int unsigned vsw, input int unsigned vb,
                                  input bit hpol, input bit vpol, input int unsigned div);
      int unsigned ht, vt, p, x, y, fc;
      bit h, v, d, ls, fs;
      logic [2:0] c;
      logic [23:0] rgb;
      ht  = ha + hf + hsw + hb;
      vt  = va + vf + vsw + vb;
      p   = e / div;
      x   = p % ht;
      y   = (p / ht) % vt;
      fc  = (p / (ht * vt)) % 65536;
      h   = (x >= ha + hf && x < ha + hf + hsw) ? hpol : !hpol;
      v   = (y >= va + vf && y < va + vf + vsw) ? vpol : !vpol;
      d   = !fr && x < ha && y < va;
      ls  = tk && x == 0;
      fs  = ls && y == 0;
      case (x / (ha / 8))
         0: c = 3'b111; 1: c = 3'b110; 2: c = 3'b011; 3: c = 3'b010;
         4: c = 3'b101; 5: c = 3'b100; 6: c = 3'b001; default: c = 3'b000;
      endcase
      rgb = d ? {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}} : 24'h0;
      return vec_t'({h, v, d, tk, ls, fs, 16'(fc), 10'(y), 10'(x)
`ifdef VGA_TEST_PATTERN_EN
                     , rgb
`endif
                    });
   endfunction

   assign exp_a = model(e_a, fresh, tk_a, HA_A, HF_A, HS_A, HB_A, VA_A, VF_A, VS_A, VB_A,
                        1'b0, 1'b0, DIV_A);
   assign exp_b = model(e_b, fresh, tk_b, HA_B, HF_B, HS_B, HB_B, VA_B, VF_B, VS_B, VB_B,
                        1'b1, 1'b0, DIV_B);

   // Drive one clk of stimulus and advance the model; returns 1 time unit after the edge.
   task automatic cycle(input bit r, input bit en);
      reset  = r;
      enable = en;
      @(posedge clk);
      if (r) begin
         e_a = 0; e_b = 0; fresh = 1'b1; tk_a = 1'b0; tk_b = 1'b0;
      end else begin
         fresh = 1'b0;
         if (en) begin e_a++; e_b++; end
         tk_a = en && (e_a % DIV_A == 0);
         tk_b = en && (e_b % DIV_B == 0);
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b1);
         n_tests++;
         if (obs_a !== exp_a) begin
            n_fail++; $display("FAIL reset_a t=%0t got %h want %h", $time, obs_a, exp_a);
         end
         n_tests++;
         if (obs_b !== exp_b) begin
            n_fail++; $display("FAIL reset_b t=%0t got %h want %h", $time, obs_b, exp_b);
         end
      end
      n_tests++;
      if ({hs_a, vs_a, disp_a, fc_a} !== {1'b1, 1'b1, 1'b0, 16'd0}) begin
         n_fail++; $display("FAIL reset_levels got %b%b%b %0d want 110 0", hs_a, vs_a, disp_a, fc_a);
      end
      cycle(1'b0, 1'b1);
      n_tests++;
      if ({disp_a, x_a} !== {1'b1, 10'd0}) begin
         n_fail++; $display("FAIL first_edge_a got disp=%b x=%0d want disp=1 x=0", disp_a, x_a);
      end
      n_tests++;
      if ({disp_b, x_b} !== {1'b1, 10'd1}) begin
         n_fail++; $display("FAIL first_edge_b got disp=%b x=%0d want disp=1 x=1", disp_b, x_b);
      end
   endtask

   task automatic test_free_run();
      cycle(1'b1, 1'b1);
      // Two full frames of DUT A: 24*12 pixels * 3 clks each.
      for (int i = 0; i < 2 * 24 * 12 * 3; i++) begin
         cycle(1'b0, 1'b1);
         n_tests++;
         if (obs_a !== exp_a) begin
            n_fail++; $display("FAIL free_run_a t=%0t got %h want %h", $time, obs_a, exp_a);
         end
         n_tests++;
         if (obs_b !== exp_b) begin
            n_fail++; $display("FAIL free_run_b t=%0t got %h want %h", $time, obs_b, exp_b);
         end
      end
      n_tests++;
      if ({fc_a, fs_a, x_a, y_a} !== {16'd2, 1'b1, 10'd0, 10'd0}) begin
         n_fail++; $display("FAIL two_frames_a got fc=%0d fs=%b x=%0d y=%0d want 2 1 0 0",
                            fc_a, fs_a, x_a, y_a);
      end
   endtask

   task automatic test_small_frame();
      cycle(1'b1, 1'b1);
      for (int i = 1; i <= 84; i++) begin
         cycle(1'b0, 1'b1);
         n_tests++;
         if (obs_b !== exp_b) begin
            n_fail++; $display("FAIL small_frame_b clk=%0d got %h want %h", i, obs_b, exp_b);
         end
         if (x_b == 10'd9 || x_b == 10'd10) begin
            n_tests++;
            if (hs_b !== 1'b1) begin
               n_fail++; $display("FAIL small_hsync clk=%0d got %b want 1", i, hs_b);
            end
         end
      end
      n_tests++;
      if ({fs_b, fc_b} !== {1'b1, 16'd1}) begin
         n_fail++; $display("FAIL small_frame_period got fs=%b fc=%0d want 1 1", fs_b, fc_b);
      end
   endtask

   task automatic test_freeze();
      int wait_clks;
      int need;
      cycle(1'b1, 1'b1);
      for (int i = 0; i < 3000 && x_a != 10'd5; i++) cycle(1'b0, 1'b1);
      n_tests++;
      if (x_a !== 10'd5) begin
         n_fail++; $display("FAIL freeze_reach got x=%0d want 5", x_a);
      end
      // Stop one clk into the next pixel so the held prescaler is non-zero.
      cycle(1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, 1'b0);
         n_tests++;
         if (obs_a !== exp_a || x_a !== 10'd5) begin
            n_fail++; $display("FAIL freeze_hold_a t=%0t got %h want %h", $time, obs_a, exp_a);
         end
         n_tests++;
         if (obs_b !== exp_b) begin
            n_fail++; $display("FAIL freeze_hold_b t=%0t got %h want %h", $time, obs_b, exp_b);
         end
      end
      need = DIV_A - (e_a % DIV_A);
      wait_clks = 0;
      while (x_a != 10'd6 && wait_clks < 20) begin
         cycle(1'b0, 1'b1);
         wait_clks++;
      end
      n_tests++;
      if (wait_clks !== need) begin
         n_fail++; $display("FAIL resume_latency got %0d clks want %0d", wait_clks, need);
      end
   endtask

   task automatic test_random_enable();
      bit en;
      cycle(1'b1, 1'b1);
      for (int i = 0; i < 4000; i++) begin
         en = ($urandom_range(0, 3) != 0);
         cycle(1'b0, en);
         n_tests++;
         if (obs_a !== exp_a) begin
            n_fail++; $display("FAIL random_enable_a t=%0t got %h want %h", $time, obs_a, exp_a);
         end
         n_tests++;
         if (obs_b !== exp_b) begin
            n_fail++; $display("FAIL random_enable_b t=%0t got %h want %h", $time, obs_b, exp_b);
         end
      end
   endtask

   task automatic test_mid_reset();
      int len;
      for (int k = 0; k < 6; k++) begin
         len = $urandom_range(100, 1500);
         for (int i = 0; i < len; i++) cycle(1'b0, $urandom_range(0, 4) != 0);
         cycle(1'b1, 1'b1);
         n_tests++;
         if (obs_a !== exp_a || {x_a, y_a, fc_a, hs_a, vs_a} !== {36'd0, 2'b11}) begin
            n_fail++; $display("FAIL mid_reset_a t=%0t got %h want %h", $time, obs_a, exp_a);
         end
         n_tests++;
         if (obs_b !== exp_b) begin
            n_fail++; $display("FAIL mid_reset_b t=%0t got %h want %h", $time, obs_b, exp_b);
         end
         cycle(1'b0, 1'b1);
         n_tests++;
         if (obs_a !== exp_a) begin
            n_fail++; $display("FAIL after_reset_a t=%0t got %h want %h", $time, obs_a, exp_a);
         end
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_small_frame();
      test_freeze();
      test_random_enable();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
